traffic_light_seq: RTL and testbench

//  Sequential controller for a highway/farm-road intersection.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/tl_dwell_timer.sv | 28 ++
 rtl/traffic_light_seq.sv | 103 ++++++++++
 tb/tb_traffic_light_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the highway/farm-road light sequencer:
// state codes, lamp codes and the per-state dwell lookup.
package traffic_pkg;

  typedef enum logic [2:0] {
    HG = 3'b000,
    HY = 3'b001,
    RF = 3'b010,
    FG = 3'b011,
    FY = 3'b100,
    RH = 3'b101
  } state_t;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;

  // Timer reload value (dwell-1) on entry to a state.
  // Illegal codes recover through RH, so they share its clearance.
  function automatic int unsigned dwell(
    input state_t      s,
    input int unsigned hwy_min,
    input int unsigned farm_max,
    input int unsigned yel_t,
    input int unsigned clr_t
  );
    case (s)
      HG:      dwell = hwy_min - 1;
      HY:      dwell = yel_t - 1;
      RF:      dwell = clr_t - 1;
      FG:      dwell = farm_max - 1;
      FY:      dwell = yel_t - 1;
      RH:      dwell = clr_t - 1;
      default: dwell = clr_t - 1;
    endcase
  endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Loadable down-counter that holds at zero.
// Drives the dwell-expired flag used by the sequencer.
module tl_dwell_timer #(
  parameter int            TW   = 5,
  parameter logic [TW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          zero
);

  // Reload on state change, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= INIT;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/traffic_light_seq.sv
// Highway/farm-road intersection sequencer: next-state
// logic, state register and Moore lamp decode.
module traffic_light_seq #(
  parameter int TW       = 5,
  parameter int HWY_MIN  = 16,
  parameter int FARM_MAX = 12,
  parameter int YEL_T    = 4,
  parameter int CLR_T    = 2
) (
  input  logic       clk_pad,
  input  logic       rst_pad,
  input  logic       car_pad,
  input  logic       emerg_pad,
  output logic [1:0] hwy_lt_pad,
  output logic [1:0] farm_lt_pad,
  output logic [2:0] state_pad,
  output logic       tmr_zero_pad
);

  import traffic_pkg::*;

  localparam int MAX_DW = 1 << TW;

  if (HWY_MIN < 1 || HWY_MIN > MAX_DW) begin : g_bad_hwy
    $error("HWY_MIN out of range for TW");
  end
  if (FARM_MAX < 1 || FARM_MAX > MAX_DW) begin : g_bad_farm
    $error("FARM_MAX out of range for TW");
  end
  if (YEL_T < 1 || YEL_T > MAX_DW) begin : g_bad_yel
    $error("YEL_T out of range for TW");
  end
  if (CLR_T < 1 || CLR_T > MAX_DW) begin : g_bad_clr
    $error("CLR_T out of range for TW");
  end

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tmr;
  logic          tmr_zero;
  logic          load;
  logic [TW-1:0] load_val;

  // State register; reset lands on highway green.
  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      state <= HG;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus timer reload on any state change.
  always_comb begin
    state_nx = state;
    case (state)
      HG: if (tmr_zero && car_pad && !emerg_pad) state_nx = HY;
      HY: if (tmr_zero) state_nx = RF;
      RF: begin
        if (emerg_pad)     state_nx = RH;
        else if (tmr_zero) state_nx = FG;
      end
      FG: if (emerg_pad || !car_pad || tmr_zero) state_nx = FY;
      FY: if (tmr_zero) state_nx = RH;
      RH: if (tmr_zero) state_nx = HG;
      default: state_nx = RH;
    endcase
    load     = (state_nx != state);
    load_val = TW'(dwell(state_nx, HWY_MIN, FARM_MAX, YEL_T, CLR_T));
  end

  tl_dwell_timer #(
    .TW   (TW),
    .INIT (TW'(HWY_MIN - 1))
  ) u_timer (
    .clk      (clk_pad),
    .rst      (rst_pad),
    .load     (load),
    .load_val (load_val),
    .value    (tmr),
    .zero     (tmr_zero)
  );

  // Moore lamp decode; anything not green/yellow shows red.
  always_comb begin
    hwy_lt_pad  = LT_RED;
    farm_lt_pad = LT_RED;
    case (state)
      HG: hwy_lt_pad  = LT_GRN;
      HY: hwy_lt_pad  = LT_YEL;
      FG: farm_lt_pad = LT_GRN;
      FY: farm_lt_pad = LT_YEL;
      default: begin
        hwy_lt_pad  = LT_RED;
        farm_lt_pad = LT_RED;
      end
    endcase
  end

  assign state_pad    = state;
  assign tmr_zero_pad = tmr_zero;

endmodule

// File: tb/tb_traffic_light_seq.sv
// Bench for traffic_light_seq: directed scenarios then random
// car/emergency traffic against an elapsed-cycle reference model.
module tb_traffic_light_seq;

  logic       clk_pad = 1'b0;
  logic       rst_pad;
  logic       car_pad;
  logic       emerg_pad;
  logic [1:0] hwy_lt_pad;
  logic [1:0] farm_lt_pad;
  logic [2:0] state_pad;
  logic       tmr_zero_pad;

  int compared   = 0;
  int mismatched = 0;

  // reference model: phase index equals state code, el = cycles spent
  int ph = 0;
  int el = 0;
  int dw[6]             = '{16, 4, 2, 12, 4, 2};
  logic [1:0] hw_lp[6]  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] fm_lp[6]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};

  traffic_light_seq dut (
    .clk_pad      (clk_pad),
    .rst_pad      (rst_pad),
    .car_pad      (car_pad),
    .emerg_pad    (emerg_pad),
    .hwy_lt_pad   (hwy_lt_pad),
    .farm_lt_pad  (farm_lt_pad),
    .state_pad    (state_pad),
    .tmr_zero_pad (tmr_zero_pad)
  );

  always #5 clk_pad = ~clk_pad;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 8'(state_pad), 8'(ph));
    chk("hwy_lamp", 8'(hwy_lt_pad), 8'(hw_lp[ph]));
    chk("farm_lamp", 8'(farm_lt_pad), 8'(fm_lp[ph]));
    chk("tmr_zero", 8'(tmr_zero_pad), 8'(el >= dw[ph] - 1));
    chk("no_dual_green",
        8'(!(hwy_lt_pad == 2'b10 && farm_lt_pad == 2'b10)), 8'd1);
  endtask

  task automatic step(input logic car, input logic em);
    int   nx;
    logic expd;
    car_pad   = car;
    emerg_pad = em;
    @(posedge clk_pad);
    expd = (el >= dw[ph] - 1);
    nx   = ph;
    case (ph)
      0: if (expd && car && !em) nx = 1;
      1: if (expd) nx = 2;
      2: if (em) nx = 5; else if (expd) nx = 3;
      3: if (em || !car || expd) nx = 4;
      4: if (expd) nx = 5;
      5: if (expd) nx = 0;
      default: nx = 5;
    endcase
    if (nx != ph) begin
      ph = nx;
      el = 0;
    end else if (el < 1000) begin
      el++;
    end
    #1;
    check_all();
  endtask

  task automatic run_until(input int phase, input logic car,
                           input logic em, input int max);
    int n = 0;
    while (ph != phase && n < max) begin
      step(car, em);
      n++;
    end
    chk("reach_phase", 8'(state_pad), 8'(phase));
  endtask

  // async reset pulse between edges; caller sits at edge+1
  task automatic mid_reset();
    #2;
    rst_pad = 1'b1;
    #1;
    ph = 0;
    el = 0;
    chk("rst_hwy", 8'(hwy_lt_pad), 8'h02);
    chk("rst_farm", 8'(farm_lt_pad), 8'h00);
    chk("rst_state", 8'(state_pad), 8'h00);
    chk("rst_zero", 8'(tmr_zero_pad), 8'h00);
    #2;
    rst_pad = 1'b0;
  endtask

  initial begin
    int   n;
    logic car;
    rst_pad   = 1'b1;
    car_pad   = 1'b0;
    emerg_pad = 1'b0;
    #12;
    ph = 0;
    el = 0;
    check_all();
    rst_pad = 1'b0;

    // 1: no traffic, highway keeps green
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
    chk("hg_hold", 8'(state_pad), 8'h00);

    // 2: car arrives then leaves during farm green
    @(posedge clk_pad);
    #1;
    mid_reset();
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    chk("back_to_hg", 8'(state_pad), 8'h00);

    // 3: farm green capped, then full highway minimum
    run_until(3, 1'b1, 1'b0, 100);
    n = 0;
    while (state_pad == 3'b011 && n < 50) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("fg_len", 8'(n), 8'd12);
    run_until(0, 1'b1, 1'b0, 100);
    n = 0;
    while (state_pad == 3'b000 && n < 50) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("hg_len", 8'(n), 8'd16);

    // 4: preempt in RF and in FG
    run_until(2, 1'b1, 1'b0, 100);
    step(1'b1, 1'b1);
    chk("emerg_rf", 8'(state_pad), 8'h05);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rh_to_hg", 8'(state_pad), 8'h00);
    run_until(3, 1'b1, 1'b0, 100);
    step(1'b1, 1'b1);
    chk("emerg_fg", 8'(state_pad), 8'h04);

    // 5: car and emergency together at highway expiry
    mid_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    chk("emerg_wins", 8'(state_pad), 8'h00);
    step(1'b1, 1'b0);
    chk("release_hy", 8'(state_pad), 8'h01);

    // 6: reset in the middle of farm green
    run_until(3, 1'b1, 1'b0, 100);
    step(1'b1, 1'b0);
    mid_reset();
    step(1'b0, 1'b0);

    // random traffic with rare preempts
    car = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) car = ~car;
      step(car, $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
